// File: rtl/cpu_pkg.sv
// +---------------------------------------------------------------------+
// | cpu_pkg: shared widths and requester encoding for the writeback arb  |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int NREGS  = 8;
   localparam int REG_W  = $clog2(NREGS);

   // Each encoding doubles as the requester's bit position in req/grant.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LD  = 1'b1
   } req_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// +---------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin arbiter with a registered priority  |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   import cpu_pkg::*;

   req_e prio_q;
   req_e prio_d;

   // Priority only moves on contention; a lone requester never disturbs it.
   always_comb begin
      grant  = 2'b00;
      prio_d = prio_q;
      if (!rst) begin
         if (req == 2'b11) begin
            if (prio_q == REQ_ALU) begin
               grant  = 2'b01;
               prio_d = REQ_LD;
            end else begin
               grant  = 2'b10;
               prio_d = REQ_ALU;
            end
         end else begin
            grant = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= REQ_ALU;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// +---------------------------------------------------------------------+
// | regfile_wb_arbiter: ALU/load writeback arbitration and scoreboard    |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int NREGS  = cpu_pkg::NREGS,
   localparam int IDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [IDX_W-1:0]  alu_reg,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [IDX_W-1:0]  ld_reg,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              issue_valid,
   input  logic [IDX_W-1:0]  issue_reg,
   output logic              reg_write_en,
   output logic [IDX_W-1:0]  write_reg,
   output logic [DATA_W-1:0] write_data,
   input  logic [IDX_W-1:0]  read_reg1,
   input  logic [IDX_W-1:0]  read_reg2,
   output logic              hazard1,
   output logic              hazard2,
   output logic [NREGS-1:0]  pending
);

   import cpu_pkg::*;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              any_grant;
   logic [IDX_W-1:0]  win_reg;
   logic [DATA_W-1:0] win_data;

   logic              wen_q,   wen_d;
   logic [IDX_W-1:0]  wreg_q,  wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NREGS-1:0]  pend_q,  pend_d;

   assign req = {ld_valid, alu_valid};

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .grant (grant)
   );

   assign alu_ready = grant[REQ_ALU];
   assign ld_ready  = grant[REQ_LD];
   assign any_grant = |grant;
   assign win_reg   = grant[REQ_LD] ? ld_reg  : alu_reg;
   assign win_data  = grant[REQ_LD] ? ld_data : alu_data;

   // Clear is applied before set so an issue to the register being written survives.
   always_comb begin
      wen_d   = any_grant;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      pend_d  = pend_q;
      if (any_grant) begin
         wreg_d          = win_reg;
         wdata_d         = win_data;
         pend_d[win_reg] = 1'b0;
      end
      if (issue_valid) begin
         pend_d[issue_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         pend_q  <= '0;
      end else begin
         wen_q   <= wen_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         pend_q  <= pend_d;
      end
   end

   // Outputs are forced to their reset values during the reset cycle itself,
   // which also kills a write that was granted just before reset rose.
   assign reg_write_en = wen_q & ~rst;
   assign write_reg    = rst ? '0 : wreg_q;
   assign write_data   = rst ? '0 : wdata_q;
   assign pending      = rst ? '0 : pend_q;

   assign hazard1 = pending[read_reg1];
   assign hazard2 = pending[read_reg2];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// +---------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed vector bench for regfile_wb_arbiter  |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_valid, ld_valid, issue_valid;
   logic [2:0] alu_reg, ld_reg, issue_reg, read_reg1, read_reg2;
   logic [7:0] alu_data, ld_data;
   logic       alu_ready, ld_ready, reg_write_en, hazard1, hazard2;
   logic [2:0] write_reg;
   logic [7:0] write_data;
   logic [7:0] pending;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic       av;  logic [2:0] ar; logic [7:0] ad;
      logic       lv;  logic [2:0] lr; logic [7:0] ld;
      logic       iv;  logic [2:0] ir;
      logic [2:0] r1;  logic [2:0] r2;
      logic       e_ardy, e_lrdy, e_h1, e_h2;
      logic       e_wen;  logic [2:0] e_wreg; logic [7:0] e_wdata; logic [7:0] e_pend;
   } vec_t;

   vec_t vecs[$];

   regfile_wb_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_reg      (alu_reg),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .ld_valid     (ld_valid),
      .ld_reg       (ld_reg),
      .ld_data      (ld_data),
      .ld_ready     (ld_ready),
      .issue_valid  (issue_valid),
      .issue_reg    (issue_reg),
      .reg_write_en (reg_write_en),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .read_reg1    (read_reg1),
      .read_reg2    (read_reg2),
      .hazard1      (hazard1),
      .hazard2      (hazard2),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rs, input logic av, input int ar, input int ad,
      input logic lv, input int lr, input int ld, input logic iv, input int ir,
      input int r1, input int r2, input logic ea, input logic el,
      input logic h1, input logic h2, input logic ew, input int ewr,
      input int ewd, input int ep);
      vec_t v;
      v.rst = rs;
      v.av = av; v.ar = 3'(ar); v.ad = 8'(ad);
      v.lv = lv; v.lr = 3'(lr); v.ld = 8'(ld);
      v.iv = iv; v.ir = 3'(ir);
      v.r1 = 3'(r1); v.r2 = 3'(r2);
      v.e_ardy = ea; v.e_lrdy = el; v.e_h1 = h1; v.e_h2 = h2;
      v.e_wen = ew; v.e_wreg = 3'(ewr); v.e_wdata = 8'(ewd); v.e_pend = 8'(ep);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rs, input logic av, input int ar, input int ad,
                        input logic lv, input int lr, input int ld,
                        input logic iv, input int ir, input int r1, input int r2);
      rst = rs;
      alu_valid = av; alu_reg = 3'(ar); alu_data = 8'(ad);
      ld_valid = lv;  ld_reg = 3'(lr);  ld_data = 8'(ld);
      issue_valid = iv; issue_reg = 3'(ir);
      read_reg1 = 3'(r1); read_reg2 = 3'(r2);
   endtask

   task automatic post_chk(input string tag, input int ew, input int ewr,
                           input int ewd, input int ep);
      chk({tag, " wen"},   int'(reg_write_en), ew);
      chk({tag, " wreg"},  int'(write_reg),    ewr);
      chk({tag, " wdata"}, int'(write_data),   ewd);
      chk({tag, " pend"},  int'(pending),      ep);
   endtask

   initial begin
      // rst av ar ad   lv lr ld   iv ir  r1 r2  ardy lrdy h1 h2  wen wreg wdata pend
      vecs.push_back(mk(1, 1,1,'hAA, 1,2,'hBB, 1,3, 0,0, 0,0,0,0, 0,0,'h00,'h00));
      vecs.push_back(mk(0, 1,2,'h05, 0,0,'h00, 0,0, 2,0, 1,0,0,0, 1,2,'h05,'h00));
      vecs.push_back(mk(0, 0,0,'h00, 0,0,'h00, 0,0, 0,0, 0,0,0,0, 0,2,'h05,'h00));
      vecs.push_back(mk(0, 1,3,'h07, 1,4,'h11, 0,0, 0,0, 1,0,0,0, 1,3,'h07,'h00));
      vecs.push_back(mk(0, 1,3,'h07, 1,4,'h11, 0,0, 0,0, 0,1,0,0, 1,4,'h11,'h00));
      vecs.push_back(mk(0, 1,3,'h07, 1,4,'h11, 0,0, 0,0, 1,0,0,0, 1,3,'h07,'h00));
      vecs.push_back(mk(0, 1,3,'h07, 1,4,'h11, 0,0, 0,0, 0,1,0,0, 1,4,'h11,'h00));
      vecs.push_back(mk(0, 0,0,'h00, 0,0,'h00, 1,5, 5,5, 0,0,0,0, 0,4,'h11,'h20));
      vecs.push_back(mk(0, 0,0,'h00, 0,0,'h00, 0,0, 5,4, 0,0,1,0, 0,4,'h11,'h20));
      vecs.push_back(mk(0, 0,0,'h00, 1,5,'h33, 0,0, 5,5, 0,1,1,1, 1,5,'h33,'h00));
      vecs.push_back(mk(0, 0,0,'h00, 0,0,'h00, 0,0, 5,0, 0,0,0,0, 0,5,'h33,'h00));
      vecs.push_back(mk(0, 1,6,'h44, 0,0,'h00, 1,6, 0,0, 1,0,0,0, 1,6,'h44,'h40));
      vecs.push_back(mk(0, 0,0,'h00, 0,0,'h00, 0,0, 6,6, 0,0,1,1, 0,6,'h44,'h40));
      vecs.push_back(mk(0, 1,1,'h12, 0,0,'h00, 0,0, 0,0, 1,0,0,0, 1,1,'h12,'h40));
      vecs.push_back(mk(0, 0,0,'h00, 1,7,'h21, 0,0, 0,0, 0,1,0,0, 1,7,'h21,'h40));
      vecs.push_back(mk(0, 0,0,'h00, 1,7,'h22, 0,0, 0,0, 0,1,0,0, 1,7,'h22,'h40));
      vecs.push_back(mk(0, 0,0,'h00, 1,7,'h23, 0,0, 0,0, 0,1,0,0, 1,7,'h23,'h40));
      vecs.push_back(mk(0, 1,0,'h01, 1,2,'h02, 0,0, 0,0, 1,0,0,0, 1,0,'h01,'h40));
      vecs.push_back(mk(0, 1,0,'h01, 1,2,'h02, 0,0, 0,0, 0,1,0,0, 1,2,'h02,'h40));
      vecs.push_back(mk(0, 1,3,'h0B, 1,4,'h0C, 0,0, 6,0, 1,0,1,0, 1,3,'h0B,'h40));
      vecs.push_back(mk(0, 1,5,'h0D, 0,0,'h00, 0,0, 0,0, 1,0,0,0, 1,5,'h0D,'h40));
      vecs.push_back(mk(0, 1,7,'h0F, 1,6,'h0E, 0,0, 0,0, 0,1,0,0, 1,6,'h0E,'h00));

      drive(1, 0,0,0, 0,0,0, 0,0, 0,0);
      @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         drive(vecs[i].rst, vecs[i].av, int'(vecs[i].ar), int'(vecs[i].ad),
               vecs[i].lv, int'(vecs[i].lr), int'(vecs[i].ld),
               vecs[i].iv, int'(vecs[i].ir), int'(vecs[i].r1), int'(vecs[i].r2));
         #1;
         chk({tag, " alu_ready"}, int'(alu_ready), int'(vecs[i].e_ardy));
         chk({tag, " ld_ready"},  int'(ld_ready),  int'(vecs[i].e_lrdy));
         chk({tag, " hazard1"},   int'(hazard1),   int'(vecs[i].e_h1));
         chk({tag, " hazard2"},   int'(hazard2),   int'(vecs[i].e_h2));
         @(posedge clk);
         #1;
         post_chk(tag, int'(vecs[i].e_wen), int'(vecs[i].e_wreg),
                  int'(vecs[i].e_wdata), int'(vecs[i].e_pend));
         @(negedge clk);
      end

      // Grant to ALU with an issue to r7, then reset in the very next cycle.
      drive(0, 1,3,'h03, 1,4,'h04, 1,7, 7,0);
      #1;
      chk("rg grant alu_ready", int'(alu_ready), 1);
      @(posedge clk);
      #1;
      post_chk("rg grant", 1, 3, 'h03, 'h80);
      @(negedge clk);
      drive(1, 1,1,'h55, 1,2,'h66, 0,0, 7,0);
      #1;
      chk("rst wen",       int'(reg_write_en), 0);
      chk("rst wreg",      int'(write_reg),    0);
      chk("rst wdata",     int'(write_data),   0);
      chk("rst pend",      int'(pending),      0);
      chk("rst alu_ready", int'(alu_ready),    0);
      chk("rst ld_ready",  int'(ld_ready),     0);
      chk("rst hazard1",   int'(hazard1),      0);
      @(posedge clk);
      #1;
      post_chk("rst post", 0, 0, 'h00, 'h00);
      @(negedge clk);

      // Priority must be back at ALU after reset despite the pre-reset flip.
      drive(0, 1,1,'h09, 1,2,'h0A, 0,0, 7,0);
      #1;
      chk("after rst alu_ready", int'(alu_ready), 1);
      chk("after rst ld_ready",  int'(ld_ready),  0);
      chk("after rst hazard1",   int'(hazard1),   0);
      @(posedge clk);
      #1;
      post_chk("after rst 1", 1, 1, 'h09, 'h00);
      @(negedge clk);
      #1;
      chk("after rst ld_ready 2", int'(ld_ready), 1);
      @(posedge clk);
      #1;
      post_chk("after rst 2", 1, 2, 'h0A, 'h00);
      @(negedge clk);
      drive(0, 0,0,0, 0,0,0, 0,0, 0,0);
      @(posedge clk);
      #1;
      post_chk("idle", 0, 2, 'h0A, 'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
